// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - clause-22 MDIO management master; MDIO_PRE_SUPPRESS_EN skips the 32-bit preamble
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_ta_error,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, GAP} state_t;

`ifdef MDIO_PRE_SUPPRESS_EN
    localparam state_t FIRST_STATE = HDR;
`else
    localparam state_t FIRST_STATE = PRE;
`endif

    state_t      state, state_n;
    logic [4:0]  slot_cnt, slot_n;
    logic [7:0]  div_cnt, div_n;
    logic        hi_phase, hi_n;
    logic        accept, done, start_slot, mid_slot;

    logic        wr_q;
    logic [13:0] hdr_q;
    logic [15:0] wdata_q;
    logic [15:0] rx_q;
    logic        ta_q;

    logic        wr_n;
    logic [13:0] hdr_n;
    logic [15:0] wdata_n;
    logic        o_n, oe_n;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign mdc       = hi_phase;

    // Command fields seen by the bit selector: live inputs on the accept edge, latched copies afterwards
    assign wr_n    = accept ? cmd_write : wr_q;
    assign hdr_n   = accept ? {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr} : hdr_q;
    assign wdata_n = accept ? cmd_wdata : wdata_q;

    // State register and MDC bit-slot timing counters
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            slot_cnt <= 5'd0;
            div_cnt  <= 8'd0;
            hi_phase <= 1'b0;
        end else begin
            state    <= state_n;
            slot_cnt <= slot_n;
            div_cnt  <= div_n;
            hi_phase <= hi_n;
        end
    end

    // Next-state: accept in IDLE, advance divider, then phase, then slot, then frame section
    always_comb begin
        state_n    = state;
        slot_n     = slot_cnt;
        div_n      = div_cnt;
        hi_n       = hi_phase;
        accept     = 1'b0;
        done       = 1'b0;
        start_slot = 1'b0;
        mid_slot   = 1'b0;
        if (state == IDLE) begin
            if (cmd_valid) begin
                accept     = 1'b1;
                start_slot = 1'b1;
                state_n    = FIRST_STATE;
                slot_n     = 5'd0;
                div_n      = 8'd0;
                hi_n       = 1'b0;
            end
        end else if (div_cnt == DIV_LAST) begin
            div_n = 8'd0;
            hi_n  = ~hi_phase;
            if (!hi_phase) begin
                mid_slot = 1'b1;
            end else begin
                start_slot = 1'b1;
                slot_n     = slot_cnt + 5'd1;
                case (state)
                    PRE:  if (slot_cnt == 5'd31) begin state_n = HDR;  slot_n = 5'd0; end
                    HDR:  if (slot_cnt == 5'd13) begin state_n = TA;   slot_n = 5'd0; end
                    TA:   if (slot_cnt == 5'd1)  begin state_n = DATA; slot_n = 5'd0; end
                    DATA: if (slot_cnt == 5'd15) begin state_n = GAP;  slot_n = 5'd0; end
                    GAP: begin
                        state_n = IDLE;
                        slot_n  = 5'd0;
                        done    = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end else begin
            div_n = div_cnt + 8'd1;
        end
    end

    // Bit and enable for the slot being entered; the bus is released outside PRE/HDR and write TA/DATA
    always_comb begin
        o_n  = 1'b1;
        oe_n = 1'b0;
        case (state_n)
            PRE: oe_n = 1'b1;
            HDR: begin
                oe_n = 1'b1;
                o_n  = hdr_n[4'd13 - slot_n[3:0]];
            end
            TA: if (wr_n) begin
                oe_n = 1'b1;
                o_n  = (slot_n == 5'd0);
            end
            DATA: if (wr_n) begin
                oe_n = 1'b1;
                o_n  = wdata_n[4'd15 - slot_n[3:0]];
            end
            default: ;
        endcase
    end

    // Command latch, pin drive, MDIO sampling on the rising MDC edge, and response capture
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            hdr_q        <= 14'd0;
            wdata_q      <= 16'd0;
            rx_q         <= 16'd0;
            ta_q         <= 1'b0;
            mdio_o       <= 1'b1;
            mdio_oe      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'd0;
            rsp_ta_error <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (accept) begin
                wr_q    <= wr_n;
                hdr_q   <= hdr_n;
                wdata_q <= wdata_n;
            end
            if (start_slot) begin
                mdio_o  <= o_n;
                mdio_oe <= oe_n;
            end
            if (mid_slot && !wr_q) begin
                if (state == TA && slot_cnt == 5'd1)
                    ta_q <= mdio_i;
                if (state == DATA)
                    rx_q <= {rx_q[14:0], mdio_i};
            end
            if (done) begin
                rsp_rdata    <= wr_q ? 16'd0 : rx_q;
                rsp_ta_error <= wr_q ? 1'b0 : ta_q;
            end
        end
    end

endmodule
